cc_ingr_resp_data_gen: RTL

// - Responder end of the ingress req/resp/data protocol: accepts a read request, grants a burst no larger than

---
 rtl/cc_ingr_pkg.sv | 35 +++
 rtl/cc_ingr_resp_data_gen_if.sv | 47 ++++
 rtl/cc_ingr_resp_gen_stat.sv | 36 +++
 rtl/cc_ingr_resp_data_gen.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cc_ingr_pkg.sv
// Shared definitions for the ingress responder: req/resp field offsets,
// beat geometry, FSM state encoding and req_err bit indices.
// Ports: none (package).
// Optional feature macro used by importers: CC_INGR_RESP_GEN_STAT_EN.
package cc_ingr_pkg;

  // req_tdata / resp_tdata field layout
  localparam int CH_LSB  = 0;
  localparam int CH_MSB  = 15;
  localparam int SOF_BIT = 16;
  localparam int EOF_BIT = 17;
  localparam int LEN_LSB = 48;
  localparam int LEN_MSB = 63;

  // One data beat carries 64 bytes (512 bits)
  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = 6;
  localparam int BEATS_W    = 10;  // ceil(32768/64) = 512 fits in 10 bits

  // req_err bit indices
  localparam int ERR_ZERO = 0;
  localparam int ERR_BIG  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Number of 64-byte beats needed to carry len bytes (rounded up)
  function automatic logic [BEATS_W-1:0] beats_of(input logic [15:0] len);
    return len[15:BEAT_SHIFT] + {{(BEATS_W-1){1'b0}}, |len[BEAT_SHIFT-1:0]};
  endfunction

endpackage

// File: rtl/cc_ingr_resp_data_gen_if.sv
// Handshake bundle between the ingress responder and its neighbours:
// req (in), resp (out), data (out) and the upstream buffer beat stream + level.
// Ports: slave = responder view, master = initiator/buffer (environment) view.
interface cc_ingr_resp_data_gen_if #(
  parameter int LEVEL_W = 20
);

  logic               req_tvalid;
  logic               req_tready;
  logic [63:0]        req_tdata;

  logic               resp_tvalid;
  logic               resp_tready;
  logic [63:0]        resp_tdata;

  logic               data_tvalid;
  logic               data_tready;
  logic [511:0]       data_tdata;

  logic [LEVEL_W-1:0] src_level;
  logic               src_tvalid;
  logic               src_tready;
  logic [511:0]       src_tdata;

  modport slave (
    input  req_tvalid, req_tdata,
    output req_tready,
    output resp_tvalid, resp_tdata,
    input  resp_tready,
    output data_tvalid, data_tdata,
    input  data_tready,
    input  src_level, src_tvalid, src_tdata,
    output src_tready
  );

  modport master (
    output req_tvalid, req_tdata,
    input  req_tready,
    input  resp_tvalid, resp_tdata,
    output resp_tready,
    input  data_tvalid, data_tdata,
    output data_tready,
    output src_level, src_tvalid, src_tdata,
    input  src_tready
  );

endinterface

// File: rtl/cc_ingr_resp_gen_stat.sv
// Statistics counters for the ingress responder (resp count, granted bytes, zero grants).
// Latency: counters update on the cycle after the resp handshake. No backpressure.
// Ports: ap_clk, ap_rst (async high), resp_hs_i, grant_i -> stat_*_o; all wrap modulo 2^N.
module cc_ingr_resp_gen_stat (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        resp_hs_i,
  input  logic [15:0] grant_i,
  output logic [31:0] stat_resp_cnt_o,
  output logic [47:0] stat_byte_cnt_o,
  output logic [31:0] stat_zero_cnt_o
);

  logic [31:0] resp_cnt_q;
  logic [47:0] byte_cnt_q;
  logic [31:0] zero_cnt_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      resp_cnt_q <= '0;
      byte_cnt_q <= '0;
      zero_cnt_q <= '0;
    end else if (resp_hs_i) begin
      resp_cnt_q <= resp_cnt_q + 32'd1;
      byte_cnt_q <= byte_cnt_q + {32'd0, grant_i};
      if (grant_i == 16'd0) begin
        zero_cnt_q <= zero_cnt_q + 32'd1;
      end
    end
  end

  assign stat_resp_cnt_o = resp_cnt_q;
  assign stat_byte_cnt_o = byte_cnt_q;
  assign stat_zero_cnt_o = zero_cnt_q;

endmodule

// File: rtl/cc_ingr_resp_data_gen.sv
// Ingress responder: accepts one read req, grants min(len, buffered), returns resp, streams granted beats.
// Latency: resp valid 1 cycle after req acceptance; data is a zero-latency pass-through of src.
// Backpressure: resp/data held while ready low; src_tready follows data_tready only in DATA.
// Ports: ap_clk, ap_rst (async high), bus (slave modport: req/resp/data/src), req_err[1:0] pulse.
// Optional: CC_INGR_RESP_GEN_STAT_EN adds stat_resp_cnt, stat_byte_cnt, stat_zero_cnt outputs.
module cc_ingr_resp_data_gen
  import cc_ingr_pkg::*;
#(
  parameter logic [15:0] MAX_BURST = 16'd32768,
  parameter int          LEVEL_W   = 20
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  cc_ingr_resp_data_gen_if.slave    bus,
  output logic [1:0]                req_err
`ifdef CC_INGR_RESP_GEN_STAT_EN
  ,
  output logic [31:0]               stat_resp_cnt,
  output logic [47:0]               stat_byte_cnt,
  output logic [31:0]               stat_zero_cnt
`endif
);

  state_e             state_q;
  logic               req_tready_q;
  logic               resp_tvalid_q;
  logic [63:0]        resp_tdata_q;
  logic [1:0]         req_err_q;
  logic [BEATS_W-1:0] beats_q;

  logic [15:0]        req_len;
  logic [15:0]        lvl_sat;
  logic [15:0]        grant_d;
  logic               len_zero;
  logic               len_big;
  logic [15:0]        resp_grant;
  logic               req_hs;
  logic               resp_hs;
  logic               data_hs;
  logic               in_data;
  logic [29:0]        unused_rsvd;

  // Reserved request bits carry nothing; resp reserved field is driven to 0.
  assign unused_rsvd = bus.req_tdata[47:18];

  assign req_len    = bus.req_tdata[LEN_MSB:LEN_LSB];
  assign resp_grant = resp_tdata_q[LEN_MSB:LEN_LSB];
  assign len_zero   = (req_len == 16'd0);
  assign len_big    = (req_len > MAX_BURST);

  // Buffered level may exceed what a 16-bit length field can express.
  assign lvl_sat = (bus.src_level > LEVEL_W'(17'h0FFFF)) ? 16'hFFFF : bus.src_level[15:0];

  always_comb begin
    grant_d = (req_len < lvl_sat) ? req_len : lvl_sat;
    if (len_zero || len_big) begin
      grant_d = 16'd0;
    end
  end

  assign in_data = (state_q == ST_DATA);
  assign req_hs  = bus.req_tvalid & req_tready_q;
  assign resp_hs = resp_tvalid_q & bus.resp_tready;
  assign data_hs = in_data & bus.src_tvalid & bus.data_tready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= ST_IDLE;
      req_tready_q  <= 1'b1;
      resp_tvalid_q <= 1'b0;
      resp_tdata_q  <= '0;
      req_err_q     <= '0;
      beats_q       <= '0;
    end else begin
      req_err_q <= '0;  // single-cycle pulse unless re-armed below
      case (state_q)
        ST_IDLE: begin
          if (req_hs) begin
            resp_tdata_q              <= '0;
            resp_tdata_q[CH_MSB:CH_LSB]   <= bus.req_tdata[CH_MSB:CH_LSB];
            resp_tdata_q[SOF_BIT]     <= bus.req_tdata[SOF_BIT];
            resp_tdata_q[EOF_BIT]     <= bus.req_tdata[EOF_BIT];
            resp_tdata_q[LEN_MSB:LEN_LSB] <= grant_d;
            req_err_q[ERR_ZERO]       <= len_zero;
            req_err_q[ERR_BIG]        <= len_big;
            req_tready_q              <= 1'b0;
            resp_tvalid_q             <= 1'b1;
            state_q                   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_hs) begin
            resp_tvalid_q <= 1'b0;
            if (resp_grant == 16'd0) begin
              req_tready_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              beats_q <= beats_of(resp_grant);
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (data_hs) begin
            beats_q <= beats_q - {{(BEATS_W-1){1'b0}}, 1'b1};
            if (beats_q == {{(BEATS_W-1){1'b0}}, 1'b1}) begin
              req_tready_q <= 1'b1;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: begin
          req_tready_q  <= 1'b1;
          resp_tvalid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_tready  = req_tready_q;
  assign bus.resp_tvalid = resp_tvalid_q;
  assign bus.resp_tdata  = resp_tdata_q;
  assign req_err         = req_err_q;

  // Data is gated to DATA so no beat can leave before its resp handshake.
  assign bus.data_tvalid = in_data & bus.src_tvalid;
  assign bus.src_tready  = in_data & bus.data_tready;
  assign bus.data_tdata  = bus.src_tdata;

`ifdef CC_INGR_RESP_GEN_STAT_EN
  cc_ingr_resp_gen_stat u_stat (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .resp_hs_i       (resp_hs),
    .grant_i         (resp_grant),
    .stat_resp_cnt_o (stat_resp_cnt),
    .stat_byte_cnt_o (stat_byte_cnt),
    .stat_zero_cnt_o (stat_zero_cnt)
  );
`endif

endmodule
